// File: rtl/alu_pkg.sv
// Shared opcodes, FSM states and flag bundle for the EXE-stage ALU.
// Flags are packed MSB-first as {N,Z,C,V} to match the status register.
package alu_pkg;

  localparam logic [3:0] OP_MOV = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_ADC = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0100;
  localparam logic [3:0] OP_SBC = 4'b0101;
  localparam logic [3:0] OP_AND = 4'b0110;
  localparam logic [3:0] OP_ORR = 4'b0111;
  localparam logic [3:0] OP_EOR = 4'b1000;
  localparam logic [3:0] OP_MVN = 4'b1001;
  localparam logic [3:0] OP_MUL = 4'b1010;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

endpackage

// File: rtl/alu_core.sv
// Combinational single-cycle ALU ops and N/Z/C/V generation.
// Ports: i_a/i_b operands, i_cmd opcode, i_c carry in; o_res, o_flg.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CMD_W = 4
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [CMD_W-1:0] i_cmd,
  input  logic             i_c,
  output logic [WIDTH-1:0] o_res,
  output flags_t           o_flg
);

  logic w_mov, w_mvn, w_add, w_adc;
  logic w_sub, w_sbc, w_and, w_orr, w_eor;
  logic [WIDTH-1:0] w_bop;
  logic [WIDTH-1:0] w_log;
  logic [WIDTH:0]   w_sum;
  logic             w_cin;
  logic             w_arith;
  logic             w_v;

  assign w_mov = (i_cmd == CMD_W'(OP_MOV));
  assign w_mvn = (i_cmd == CMD_W'(OP_MVN));
  assign w_add = (i_cmd == CMD_W'(OP_ADD));
  assign w_adc = (i_cmd == CMD_W'(OP_ADC));
  assign w_sub = (i_cmd == CMD_W'(OP_SUB));
  assign w_sbc = (i_cmd == CMD_W'(OP_SBC));
  assign w_and = (i_cmd == CMD_W'(OP_AND));
  assign w_orr = (i_cmd == CMD_W'(OP_ORR));
  assign w_eor = (i_cmd == CMD_W'(OP_EOR));

  // Subtraction reuses the adder as a + ~b + cin.
  always_comb begin
    w_bop   = '0;
    w_cin   = 1'b0;
    w_arith = 1'b0;
    w_log   = '0;
    unique case (1'b1)
      w_mov: w_log = i_b;
      w_mvn: w_log = ~i_b;
      w_add: begin
        w_bop   = i_b;
        w_arith = 1'b1;
      end
      w_adc: begin
        w_bop   = i_b;
        w_cin   = i_c;
        w_arith = 1'b1;
      end
      w_sub: begin
        w_bop   = ~i_b;
        w_cin   = 1'b1;
        w_arith = 1'b1;
      end
      w_sbc: begin
        w_bop   = ~i_b;
        w_cin   = i_c;
        w_arith = 1'b1;
      end
      w_and: w_log = i_a & i_b;
      w_orr: w_log = i_a | i_b;
      w_eor: w_log = i_a ^ i_b;
      default: w_log = '0;
    endcase
  end

  assign w_sum = {1'b0, i_a}
               + {1'b0, w_bop}
               + {{WIDTH{1'b0}}, w_cin};

  assign o_res = w_arith ? w_sum[WIDTH-1:0] : w_log;

  // Overflow: adder inputs share a sign the result lacks.
  assign w_v = w_arith
             && (i_a[WIDTH-1] == w_bop[WIDTH-1])
             && (w_sum[WIDTH-1] != i_a[WIDTH-1]);

  assign o_flg = '{
    n: o_res[WIDTH-1],
    z: (o_res == '0),
    c: w_arith & w_sum[WIDTH],
    v: w_v
  };

endmodule

// File: rtl/pipelined_alu.sv
// EXE-stage ALU: registered result/flags, valid/ready on both sides,
// iterative shift-add MUL. Ports: in_*/out_* handshake, result, C/V/Z/N.
module pipelined_alu
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int CMD_W  = 4,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [CMD_W-1:0] EXE_CMD,
  input  logic             C_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             C,
  output logic             V,
  output logic             Z,
  output logic             N
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic             r_cmul;
  logic [WIDTH-1:0] r_result;
  flags_t           r_flags;
  logic             r_out_valid;

  logic             w_accept;
  logic             w_is_mul;
  logic             w_mul_done;
  logic [WIDTH-1:0] w_acc_nxt;
  logic [WIDTH-1:0] w_core_res;
  flags_t           w_core_flg;

  alu_core #(
    .WIDTH (WIDTH),
    .CMD_W (CMD_W)
  ) u_core (
    .i_a   (in1),
    .i_b   (in2),
    .i_cmd (EXE_CMD),
    .i_c   (C_in),
    .o_res (w_core_res),
    .o_flg (w_core_flg)
  );

  assign in_ready = (r_state == IDLE)
                  && (!r_out_valid || out_ready);
  assign w_accept = in_valid && in_ready;
  assign w_is_mul = MUL_EN
                  && (EXE_CMD == CMD_W'(OP_MUL));

  assign w_acc_nxt  = r_acc
                    + (r_mplier[0] ? r_mcand : '0);
  assign w_mul_done = (r_state == MUL)
                    && (r_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_acc       <= '0;
      r_cmul      <= 1'b0;
      r_result    <= '0;
      r_flags     <= '0;
      r_out_valid <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_accept && w_is_mul) begin
            r_state  <= MUL;
            r_cnt    <= CNT_W'(WIDTH - 1);
            r_mcand  <= in1;
            r_mplier <= in2;
            r_acc    <= '0;
            r_cmul   <= C_in;
          end
        end
        MUL: begin
          r_acc    <= w_acc_nxt;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt - CNT_W'(1);
          if (r_cnt == '0) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase

      // A MUL in flight implies in_ready=0, so the
      // three sources below never collide.
      if (w_accept && !w_is_mul) begin
        r_result    <= w_core_res;
        r_flags     <= w_core_flg;
        r_out_valid <= 1'b1;
      end else if (w_mul_done) begin
        r_result    <= w_acc_nxt;
        r_flags     <= '{
          n: w_acc_nxt[WIDTH-1],
          z: (w_acc_nxt == '0),
          c: r_cmul,
          v: 1'b0
        };
        r_out_valid <= 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign N         = r_flags.n;
  assign Z         = r_flags.z;
  assign C         = r_flags.c;
  assign V         = r_flags.v;

endmodule

// File: tb/tb_pipelined_alu.sv
// Self-checking bench for pipelined_alu: directed scenarios
// plus a randomized run against a behavioural model.
module tb_pipelined_alu;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in1 = '0;
  logic [W-1:0] in2 = '0;
  logic [3:0]   EXE_CMD = '0;
  logic         C_in = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic         C, V, Z, N;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipelined_alu #(
    .WIDTH  (W),
    .CMD_W  (4),
    .MUL_EN (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in1       (in1),
    .in2       (in2),
    .EXE_CMD   (EXE_CMD),
    .C_in      (C_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .C         (C),
    .V         (V),
    .Z         (Z),
    .N         (N)
  );

  // Reference: {N,Z,C,V,result} from plain integer arithmetic.
  function automatic logic [W+3:0] ref_alu(
    input logic [3:0]   op,
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input logic         ci
  );
    longint unsigned ua = a;
    longint unsigned ub = b;
    longint unsigned u;
    longint sa = $signed(a);
    longint sb = $signed(b);
    longint s;
    longint unsigned bin;
    logic [W-1:0] r = '0;
    logic c = 1'b0;
    logic v = 1'b0;
    case (op)
      4'h1: r = b;
      4'h9: r = ~b;
      4'h6: r = a & b;
      4'h7: r = a | b;
      4'h8: r = a ^ b;
      4'h2, 4'h3: begin
        bin = (op == 4'h3 && ci) ? 1 : 0;
        u = ua + ub + bin;
        r = u[W-1:0];
        c = (u >= (64'd1 << W));
        s = sa + sb + longint'(bin);
        v = (s != longint'($signed(r)));
      end
      4'h4, 4'h5: begin
        bin = (op == 4'h5 && !ci) ? 1 : 0;
        u = ua - ub - bin;
        r = u[W-1:0];
        c = (ua >= ub + bin);
        s = sa - sb - longint'(bin);
        v = (s != longint'($signed(r)));
      end
      4'hA: begin
        u = ua * ub;
        r = u[W-1:0];
        c = ci;
      end
      default: r = '0;
    endcase
    return {r[W-1], (r == '0), c, v, r};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(
    input logic [3:0]   op,
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input logic         ci
  );
    in_valid = 1'b1;
    EXE_CMD  = op;
    in1      = a;
    in2      = b;
    C_in     = ci;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    out_ready = 1'b1;
    drive(4'h1, '0, 32'h5, 1'b1);
    tick;
    tick;
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_valid: got %b want 0", out_valid);
    end
    checks++;
    if (result !== '0) begin
      failures++;
      $display("FAIL reset_result: got %h want 0", result);
    end
    checks++;
    if ({N, Z, C, V} !== 4'b0) begin
      failures++;
      $display("FAIL reset_flags: got %b want 0000", {N, Z, C, V});
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_add_flags;
    drive(4'h2, 32'h7FFFFFFF, 32'h1, 1'b0);
    tick;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL add_valid: got %b want 1", out_valid);
    end
    checks++;
    if ({N, Z, C, V, result} !== {4'b1001, 32'h80000000}) begin
      failures++;
      $display("FAIL add_flags: got %b %h want 1001 80000000",
               {N, Z, C, V}, result);
    end
  endtask

  task automatic test_sub_back_to_back;
    out_ready = 1'b1;
    drive(4'h4, 32'd5, 32'd5, 1'b0);
    tick;
    checks++;
    if ({out_valid, N, Z, C, V, result} !== {5'b10110, 32'h0}) begin
      failures++;
      $display("FAIL sub_eq: got v=%b %b %h want v=1 0110 0",
               out_valid, {N, Z, C, V}, result);
    end
    drive(4'h4, 32'd3, 32'd5, 1'b0);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL sub_ready: got %b want 1", in_ready);
    end
    tick;
    in_valid = 1'b0;
    checks++;
    if ({out_valid, N, Z, C, V, result} !== {5'b11000, 32'hFFFFFFFE}) begin
      failures++;
      $display("FAIL sub_neg: got v=%b %b %h want v=1 1000 fffffffe",
               out_valid, {N, Z, C, V}, result);
    end
  endtask

  task automatic test_carry_in;
    drive(4'h5, 32'd10, 32'd3, 1'b0);
    tick;
    checks++;
    if ({N, Z, C, V, result} !== {4'b0010, 32'd6}) begin
      failures++;
      $display("FAIL sbc: got %b %h want 0010 6", {N, Z, C, V}, result);
    end
    drive(4'h3, 32'hFFFFFFFF, 32'h0, 1'b1);
    tick;
    in_valid = 1'b0;
    checks++;
    if ({N, Z, C, V, result} !== {4'b0110, 32'h0}) begin
      failures++;
      $display("FAIL adc: got %b %h want 0110 0", {N, Z, C, V}, result);
    end
  endtask

  task automatic test_mul;
    int bad = 0;
    out_ready = 1'b1;
    drive(4'hA, 32'h0000FFFF, 32'h00010001, 1'b1);
    tick;
    in_valid = 1'b0;
    C_in = 1'b0;
    EXE_CMD = 4'h0;
    for (int i = 0; i < W; i++) begin
      if (in_ready !== 1'b0 || out_valid !== 1'b0) bad++;
      tick;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL mul_busy: %0d cycles with ready/valid set, want 0", bad);
    end
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL mul_valid: got %b want 1 at k+%0d", out_valid, W);
    end
    checks++;
    if ({N, Z, C, V, result} !== {4'b1010, 32'hFFFFFFFF}) begin
      failures++;
      $display("FAIL mul_result: got %b %h want 1010 ffffffff",
               {N, Z, C, V}, result);
    end
  endtask

  task automatic test_backpressure;
    int bad = 0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    drive(4'h6, 32'hF0F0F0F0, 32'h0FF00FF0, 1'b0);
    tick;
    drive(4'h1, '0, 32'hDEAD, 1'b0);
    for (int i = 0; i < 5; i++) begin
      if (out_valid !== 1'b1 || in_ready !== 1'b0
          || result !== 32'h00F000F0) bad++;
      tick;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL bp_hold: %0d bad hold cycles, want 0 (res=%h)",
               bad, result);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || result !== 32'h00F000F0) begin
      failures++;
      $display("FAIL bp_release: got rdy=%b res=%h want 1 00f000f0",
               in_ready, result);
    end
    tick;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_drain: got %b want 0", out_valid);
    end
  endtask

  task automatic test_reset_mid_mul;
    int spur = 0;
    out_ready = 1'b1;
    drive(4'hA, 32'h1234, 32'h5678, 1'b1);
    tick;
    in_valid = 1'b0;
    repeat (9) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    checks++;
    if ({out_valid, N, Z, C, V, result} !== '0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_mul: got v=%b %b %h rdy=%b want 0 0000 0 1",
               out_valid, {N, Z, C, V}, result, in_ready);
    end
    drive(4'h1, '0, 32'h1234, 1'b0);
    tick;
    in_valid = 1'b0;
    checks++;
    if ({out_valid, N, Z, C, V, result} !== {5'b10000, 32'h1234}) begin
      failures++;
      $display("FAIL rst_mov: got v=%b %b %h want 1 0000 1234",
               out_valid, {N, Z, C, V}, result);
    end
    repeat (W + 2) begin
      tick;
      if (out_valid) spur++;
    end
    checks++;
    if (spur != 0) begin
      failures++;
      $display("FAIL rst_spurious: %0d valid cycles, want 0", spur);
    end
  endtask

  task automatic test_random;
    logic         m_ov = 1'b0;
    logic         m_rdy;
    int           m_busy = 0;
    logic [W+3:0] m_out = '0;
    logic [W+3:0] m_pend = '0;
    rst = 1'b1;
    in_valid = 1'b0;
    tick;
    rst = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      checks++;
      if (out_valid !== m_ov) begin
        failures++;
        $display("FAIL rnd_valid c%0d: got %b want %b", cyc, out_valid, m_ov);
      end
      if (m_ov) begin
        checks++;
        if ({N, Z, C, V, result} !== m_out) begin
          failures++;
          $display("FAIL rnd_out c%0d: got %b %h want %b %h", cyc,
                   {N, Z, C, V}, result, m_out[W+3:W], m_out[W-1:0]);
        end
      end
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      EXE_CMD   = 4'($urandom_range(0, 15));
      in1       = $urandom();
      in2       = $urandom();
      C_in      = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0: in1 = 32'h7FFFFFFF;
        1: in2 = 32'h80000000;
        2: in2 = in1;
        3: in1 = 32'hFFFFFFFF;
        default: ;
      endcase
      m_rdy = (m_busy == 0) && (!m_ov || out_ready);
      #1;
      checks++;
      if (in_ready !== m_rdy) begin
        failures++;
        $display("FAIL rnd_ready c%0d: got %b want %b", cyc, in_ready, m_rdy);
      end
      @(posedge clk);
      if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) begin
          m_ov  = 1'b1;
          m_out = m_pend;
        end
      end else if (in_valid && m_rdy) begin
        if (EXE_CMD == 4'hA) begin
          m_busy = W;
          m_pend = ref_alu(EXE_CMD, in1, in2, C_in);
          m_ov   = 1'b0;
        end else begin
          m_ov  = 1'b1;
          m_out = ref_alu(EXE_CMD, in1, in2, C_in);
        end
      end else if (out_ready) begin
        m_ov = 1'b0;
      end
      #1;
    end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset;
    test_add_flags;
    test_sub_back_to_back;
    test_carry_in;
    test_mul;
    test_backpressure;
    test_reset_mid_mul;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
